// File: rtl/fadd_ftoi_seq.sv
// Iterative IEEE-754 single to saturated int32 converter with RNE rounding.
// Optional macro FTOI_TRUNC_EN adds a per-operation round-toward-zero input.
module fadd_ftoi_seq #(
   parameter int unsigned STEP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
`ifdef FTOI_TRUNC_EN
   input  logic        trunc,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] res,
   output logic        ovf
);

   localparam int unsigned CW = 5;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND, S_DONE} state_t;

   state_t          r_state;
   logic            r_s;
   logic            r_left;
   logic            r_trunc;
   logic [31:0]     r_mag;
   logic            r_g;
   logic            r_st;
   logic [CW-1:0]   r_cnt;
   logic [31:0]     r_res;
   logic            r_ovf;
   logic            r_out_valid;

   logic [7:0]      w_e;
   logic [23:0]     w_m;
   logic [7:0]      w_rdist;
   logic [CW-1:0]   w_cnt0;
   logic            w_trunc_in;
   logic [CW-1:0]   w_amt;
   logic [31:0]     w_mask;
   logic [31:0]     w_low;
   logic            w_gbit;
   logic            w_st_nx;
   logic            w_inc;
   logic [31:0]     w_rmag;
   logic [31:0]     w_sat;

`ifdef FTOI_TRUNC_EN
   assign w_trunc_in = trunc;
`else
   assign w_trunc_in = 1'b0;
`endif

   assign in_ready  = (r_state == S_IDLE) & ~rst;
   assign out_valid = r_out_valid;
   assign res       = r_res;
   assign ovf       = r_ovf;

   // Operand unpack, per-cycle shift slice and rounding increment
   always_comb begin
      w_e     = a[30:23];
      w_m     = {|a[30:23], a[22:0]};
      w_rdist = 8'd150 - w_e;
      w_cnt0  = 5'd0;
      if (w_e > 8'd150)
         w_cnt0 = CW'(w_e - 8'd150);
      else if (w_rdist > 8'd25)
         w_cnt0 = 5'd25;
      else
         w_cnt0 = CW'(w_rdist);
      w_sat   = (a[31] && !(w_e == 8'd255 && a[22:0] != 23'd0)) ? 32'h8000_0000 : 32'h7FFF_FFFF;

      w_amt   = (r_cnt < CW'(STEP)) ? r_cnt : CW'(STEP);
      w_mask  = (32'd1 << w_amt) - 32'd1;
      w_low   = r_mag & w_mask;
      w_gbit  = 1'b0;
      if (w_amt != 5'd0)
         w_gbit = r_mag[w_amt - 5'd1];
      // Bits below the new guard, plus the old guard, fold into sticky
      w_st_nx = r_st | r_g | (|(w_low & (w_mask >> 1)));

      w_inc   = r_g & (r_st | r_mag[0]) & ~r_trunc;
      w_rmag  = r_mag + {31'd0, w_inc};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_s         <= 1'b0;
         r_left      <= 1'b0;
         r_trunc     <= 1'b0;
         r_mag       <= 32'd0;
         r_g         <= 1'b0;
         r_st        <= 1'b0;
         r_cnt       <= 5'd0;
         r_res       <= 32'd0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_s     <= a[31];
                  r_trunc <= w_trunc_in;
                  r_mag   <= {8'd0, w_m};
                  r_g     <= 1'b0;
                  r_st    <= 1'b0;
                  r_left  <= (w_e > 8'd150);
                  r_cnt   <= w_cnt0;
                  if (a == 32'hCF00_0000) begin
                     r_res       <= 32'h8000_0000;
                     r_ovf       <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else if (w_e >= 8'd158) begin
                     r_res       <= w_sat;
                     r_ovf       <= 1'b1;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else if (w_e == 8'd0) begin
                     r_res       <= 32'd0;
                     r_ovf       <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else if (w_e == 8'd150) begin
                     r_state <= S_ROUND;
                  end else begin
                     r_state <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               if (r_left) begin
                  r_mag <= r_mag << w_amt;
               end else begin
                  r_mag <= r_mag >> w_amt;
                  r_g   <= w_gbit;
                  r_st  <= w_st_nx;
               end
               r_cnt <= r_cnt - w_amt;
               if (r_cnt == w_amt)
                  r_state <= S_ROUND;
            end
            S_ROUND: begin
               r_res       <= r_s ? (32'd0 - w_rmag) : w_rmag;
               r_ovf       <= 1'b0;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fadd_ftoi_seq.sv
// Directed self-checking bench for fadd_ftoi_seq (STEP=1 and STEP=8 instances).
module tb_fadd_ftoi_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid1, in_valid8;
   logic        in_ready1, in_ready8;
   logic [31:0] a;
   logic        out_ready;
   logic        out_valid1, out_valid8;
   logic [31:0] res1, res8;
   logic        ovf1, ovf8;
`ifdef FTOI_TRUNC_EN
   logic        trunc;
`endif

   logic        tsel;
   logic        m_in_ready, m_out_valid, m_ovf;
   logic [31:0] m_res;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fadd_ftoi_seq #(.STEP(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a),
`ifdef FTOI_TRUNC_EN
      .trunc(trunc),
`endif
      .out_valid(out_valid1), .out_ready(out_ready), .res(res1), .ovf(ovf1));

   fadd_ftoi_seq #(.STEP(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a),
`ifdef FTOI_TRUNC_EN
      .trunc(trunc),
`endif
      .out_valid(out_valid8), .out_ready(out_ready), .res(res8), .ovf(ovf8));

   assign m_in_ready  = tsel ? in_ready8  : in_ready1;
   assign m_out_valid = tsel ? out_valid8 : out_valid1;
   assign m_res       = tsel ? res8       : res1;
   assign m_ovf       = tsel ? ovf8       : ovf1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   // Issue one operand with out_ready=1, measure latency, take the result
   task automatic vec(input string tag, input logic sel, input logic [31:0] av,
                      input logic [31:0] exp_res, input logic exp_ovf, input int exp_lat);
      int n;
      int lat;
      tsel      = sel;
      a         = av;
      out_ready = 1'b1;
      n = 0;
      while (!m_in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (sel) in_valid8 = 1'b1; else in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      in_valid8 = 1'b0;
      lat = 0;
      while (!m_out_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      chk({tag, ".res"}, m_res, exp_res);
      chk({tag, ".ovf"}, 32'(m_ovf), 32'(exp_ovf));
      if (exp_lat >= 0)
         chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      @(posedge clk); #1;
      chk({tag, ".ov_clr"}, 32'(m_out_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] held;
      rst       = 1'b1;
      in_valid1 = 1'b0;
      in_valid8 = 1'b0;
      a         = 32'd0;
      out_ready = 1'b1;
      tsel      = 1'b0;
`ifdef FTOI_TRUNC_EN
      trunc     = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst.out_valid", 32'(out_valid1), 32'd0);
      chk("rst.res", res1, 32'd0);
      chk("rst.ovf", 32'(ovf1), 32'd0);
      chk("rst.in_ready", 32'(in_ready1), 32'd0);
      rst = 1'b0;
      #1;
      chk("idle.in_ready", 32'(in_ready1), 32'd1);

      vec("one_s1",   1'b0, 32'h3F80_0000, 32'h0000_0001, 1'b0, 24);
      vec("one_s8",   1'b1, 32'h3F80_0000, 32'h0000_0001, 1'b0, 4);
      vec("p2p5",     1'b0, 32'h4020_0000, 32'h0000_0002, 1'b0, 23);
      vec("p3p5",     1'b0, 32'h4060_0000, 32'h0000_0004, 1'b0, -1);
      vec("n2p5",     1'b0, 32'hC020_0000, 32'hFFFF_FFFE, 1'b0, -1);
      vec("p0p5",     1'b0, 32'h3F00_0000, 32'h0000_0000, 1'b0, -1);
      vec("p0p75",    1'b0, 32'h3F40_0000, 32'h0000_0001, 1'b0, -1);
      vec("n3p5_s8",  1'b1, 32'hC060_0000, 32'hFFFF_FFFC, 1'b0, 4);
      vec("left7",    1'b0, 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 8);
      vec("cnt0",     1'b0, 32'h4B00_0001, 32'd8388609,   1'b0, 1);
      vec("sat_pos",  1'b0, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 0);
      vec("min_int",  1'b0, 32'hCF00_0000, 32'h8000_0000, 1'b0, 0);
      vec("ninf",     1'b0, 32'hFF80_0000, 32'h8000_0000, 1'b1, 0);
      vec("nan",      1'b0, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 0);
      vec("nan_neg",  1'b0, 32'hFFC0_0000, 32'h7FFF_FFFF, 1'b1, 0);
      vec("nzero",    1'b0, 32'h8000_0000, 32'h0000_0000, 1'b0, 0);
      vec("tiny_neg", 1'b0, 32'hBE80_0000, 32'h0000_0000, 1'b0, -1);

      // Back-pressure: result must hold while out_ready is low
      tsel      = 1'b0;
      a         = 32'h4020_0000;
      out_ready = 1'b0;
      in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      for (int i = 0; i < 40 && !out_valid1; i++) begin
         @(posedge clk); #1;
      end
      chk("bp.valid", 32'(out_valid1), 32'd1);
      held = res1;
      chk("bp.res", held, 32'h0000_0002);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp.hold_valid", 32'(out_valid1), 32'd1);
         chk("bp.hold_res", res1, 32'h0000_0002);
         chk("bp.in_ready", 32'(in_ready1), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp.release_valid", 32'(out_valid1), 32'd0);
      chk("bp.release_ready", 32'(in_ready1), 32'd1);
      chk("bp.res_kept", res1, 32'h0000_0002);

      // Reset in the middle of a shift sequence
      a         = 32'h3F80_0000;
      in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("abort.busy", 32'(in_ready1), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort.ready_in_rst", 32'(in_ready1), 32'd0);
      rst = 1'b0;
      #1;
      chk("abort.out_valid", 32'(out_valid1), 32'd0);
      chk("abort.in_ready", 32'(in_ready1), 32'd1);
      vec("after_abort", 1'b0, 32'h4000_0000, 32'h0000_0002, 1'b0, 23);

`ifdef FTOI_TRUNC_EN
      trunc = 1'b1;
      vec("trz_p", 1'b0, 32'h3FF0_0000, 32'h0000_0001, 1'b0, -1);
      vec("trz_n", 1'b0, 32'hBFF0_0000, 32'hFFFF_FFFF, 1'b0, -1);
      vec("trz_sat", 1'b0, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 0);
      trunc = 1'b0;
      vec("rne_p", 1'b0, 32'h3FF0_0000, 32'h0000_0002, 1'b0, -1);
      vec("rne_n", 1'b0, 32'hBFF0_0000, 32'hFFFF_FFFE, 1'b0, -1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
